spi_mem_master_arb: RTL and testbench

//  SPI master plus request arbiter in front of the spiMemory slave. Accepts byte read/write

---
 rtl/spi_mem_master_arb.sv | 214 +++++++++++++++++++++
 tb/tb_spi_mem_master_arb.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_mem_master_arb.sv
// SPI master for the spiMemory slave, fronted by an NREQ-way byte request arbiter.
// Build option: define SPI_FIXED_PRIO_EN for fixed priority (lowest index wins); round robin otherwise.
module spi_mem_master_arb #(
  parameter int NREQ     = 2,
  parameter int CLK_DIV  = 4,
  parameter int LAG_BITS = 1,
  parameter int GAP_CLKS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      req_rw,
  input  logic [NREQ*7-1:0]    req_addr,
  input  logic [NREQ*8-1:0]    req_wdata,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic [7:0]           rdata,
  output logic                 busy,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);
  localparam int RD_BITS = 16 + LAG_BITS;
  localparam int BW      = $clog2(RD_BITS + 1);
  localparam int DMAX    = (CLK_DIV > GAP_CLKS) ? CLK_DIV : GAP_CLKS;
  localparam int DW      = $clog2(DMAX + 1);
  localparam int PW      = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT_LO, SHIFT_HI, HOLD, GAP} state_e;

  state_e            state_q, state_d;
  logic [DW-1:0]     div_q, div_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [15:0]       tx_q, tx_d;
  logic [7:0]        rx_q, rx_d, rdata_q, rdata_d;
  logic              rw_q, rw_d, mosi_q, mosi_d;
  logic [NREQ-1:0]   own_q, own_d, gnt_q, gnt_d, done_q, done_d;
  logic              sclk_q, cs_n_q, busy_q;
  logic [1:0]        miso_sync_q;

  logic              found;
  logic [PW-1:0]     win, cand;
  logic [NREQ-1:0]   win_oh;
  logic              sel_rw;
  logic [6:0]        sel_addr;
  logic [7:0]        sel_wdata;
  logic              phase_end;
  logic [BW-1:0]     last_bit;

`ifndef SPI_FIXED_PRIO_EN
  logic [PW-1:0]     ptr_q;
  int                idx;
`endif

  // Arbiter: the last hit of the descending search is the first in priority order.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    found = 1'b0;
    win   = '0;
    cand  = '0;
`ifdef SPI_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      cand = PW'(i);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`else
    idx = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      cand = PW'(idx);
      if (req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
`endif
    win_oh    = '0;
    sel_rw    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win == PW'(i)) begin
        win_oh[i] = 1'b1;
        sel_rw    = req_rw[i];
        sel_addr  = req_addr[7*i +: 7];
        sel_wdata = req_wdata[8*i +: 8];
      end
    end
  end

  assign phase_end = (div_q == DW'(CLK_DIV - 1));
  assign last_bit  = rw_q ? BW'(RD_BITS - 1) : BW'(15);

  always_comb begin
    state_d = state_q;
    div_d   = (state_q == IDLE) ? '0 : div_q + 1'b1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    mosi_d  = mosi_q;
    own_d   = own_q;
    gnt_d   = '0;
    done_d  = '0;
    unique case (state_q)
      IDLE: if (found) begin
        state_d = SETUP;
        bit_d   = '0;
        own_d   = win_oh;
        gnt_d   = win_oh;
        rw_d    = sel_rw;
        // Reads shift out zeros after the command byte.
        tx_d    = {sel_addr, sel_rw, sel_rw ? 8'h00 : sel_wdata};
      end
      SETUP: if (phase_end) begin
        state_d = SHIFT_LO;
        div_d   = '0;
        mosi_d  = tx_q[15];
        tx_d    = {tx_q[14:0], 1'b0};
      end
      SHIFT_LO: if (phase_end) begin
        state_d = SHIFT_HI;
        div_d   = '0;
      end
      SHIFT_HI: if (phase_end) begin
        div_d = '0;
        rx_d  = {rx_q[6:0], miso_sync_q[1]};
        if (bit_q == last_bit) begin
          state_d = HOLD;
        end else begin
          state_d = SHIFT_LO;
          bit_d   = bit_q + 1'b1;
          mosi_d  = tx_q[15];
          tx_d    = {tx_q[14:0], 1'b0};
        end
      end
      HOLD: if (phase_end) begin
        state_d = GAP;
        div_d   = '0;
        mosi_d  = 1'b0;
        done_d  = own_q;
        if (rw_q) rdata_d = rx_q;
      end
      GAP: if (div_q == DW'(GAP_CLKS - 1)) begin
        state_d = IDLE;
        div_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // SPI pins and busy are registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      div_q       <= '0;
      bit_q       <= '0;
      tx_q        <= '0;
      rx_q        <= '0;
      rdata_q     <= '0;
      rw_q        <= 1'b0;
      mosi_q      <= 1'b0;
      own_q       <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      sclk_q      <= 1'b1;
      cs_n_q      <= 1'b1;
      busy_q      <= 1'b0;
      miso_sync_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      state_q     <= state_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      tx_q        <= tx_d;
      rx_q        <= rx_d;
      rdata_q     <= rdata_d;
      rw_q        <= rw_d;
      mosi_q      <= mosi_d;
      own_q       <= own_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      sclk_q      <= (state_d != SHIFT_LO);
      cs_n_q      <= (state_d == IDLE) || (state_d == GAP);
      busy_q      <= (state_d != IDLE);
      miso_sync_q <= {miso_sync_q[0], miso};
    end
  end

`ifndef SPI_FIXED_PRIO_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= '0;
    end else if (gnt_d != '0) begin
      ptr_q <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
    end
  end
`endif

  assign gnt   = gnt_q;
  assign done  = done_q;
  assign rdata = rdata_q;
  assign busy  = busy_q;
  assign sclk  = sclk_q;
  assign cs_n  = cs_n_q;
  assign mosi  = mosi_q;

endmodule

// File: tb/tb_spi_mem_master_arb.sv
// Self-checking bench for spi_mem_master_arb: behavioural spiMemory slave plus a scoreboard of expected frames.
module tb_spi_mem_master_arb;
  localparam int NREQ     = 2;
  localparam int CLK_DIV  = 4;
  localparam int LAG_BITS = 1;
  localparam int GAP_CLKS = 8;
  localparam int WR_CS    = 136;
  localparam int RD_CS    = 144;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req, req_rw;
  logic [NREQ*7-1:0] req_addr;
  logic [NREQ*8-1:0] req_wdata;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rdata;
  logic              busy, sclk, cs_n, mosi;
  logic              miso = 1'b0;

  spi_mem_master_arb #(
    .NREQ(NREQ), .CLK_DIV(CLK_DIV), .LAG_BITS(LAG_BITS), .GAP_CLKS(GAP_CLKS)
  ) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .busy(busy),
    .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  typedef struct {
    int         idx;
    bit         rw;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rd;
  } item_t;

  item_t      sb[$];
  logic [7:0] ref_mem [128];
  logic [7:0] s_mem   [128];
  logic [7:0] last_rd = 8'h00;

  // spiMemory slave: captures mosi on sclk rise, drives read data on sclk fall after the lag bits.
  logic [31:0] s_shift = '0;
  int          s_cnt   = 0;
  bit          s_rw    = 1'b0;
  logic [6:0]  s_addr  = '0;

  always @(negedge cs_n) begin
    s_cnt   = 0;
    s_shift = '0;
    s_rw    = 1'b0;
  end

  always @(posedge sclk) begin
    if (!cs_n) begin
      s_shift = {s_shift[30:0], mosi};
      s_cnt++;
      if (s_cnt == 8) begin
        s_addr = s_shift[7:1];
        s_rw   = s_shift[0];
      end
      if (s_cnt == 16 && !s_rw) s_mem[s_addr] = s_shift[7:0];
    end
  end

  always @(negedge sclk) begin : slave_drive
    logic [7:0] b;
    if (!cs_n && s_rw && s_cnt >= 8 + LAG_BITS && s_cnt < 16 + LAG_BITS) begin
      b    = s_mem[s_addr];
      miso = b[7 - (s_cnt - 8 - LAG_BITS)];
    end
  end

  // Frame monitor and scoreboard consumer, sampled on the falling clk edge.
  int  low_len = 0, hi_len = 0, rise_cnt = 0;
  int  n_gnt = 0, n_done = 0, n_csfall = 0;
  bit  prev_cs = 1'b1, prev_sclk = 1'b1, have_prev = 1'b0;

  always @(negedge clk) begin : mon
    item_t it;
    if (reset) begin
      prev_cs   = 1'b1;
      prev_sclk = 1'b1;
      have_prev = 1'b0;
      hi_len    = 0;
    end else begin
      if (!cs_n) begin
        if (prev_cs) begin
          if (have_prev) check("cs_n high gap >= GAP_CLKS", 32'(hi_len >= GAP_CLKS), 1);
          low_len  = 1;
          rise_cnt = 0;
          n_csfall++;
        end else begin
          low_len++;
        end
        if (!prev_sclk && sclk) rise_cnt++;
      end else begin
        hi_len = prev_cs ? hi_len + 1 : 1;
      end
      if (gnt != '0) begin
        n_gnt++;
        if (sb.size() == 0) check("unexpected gnt", 32'(gnt), 0);
        else                check("gnt onehot", 32'(gnt), 32'(1) << sb[0].idx);
      end
      if (done != '0) begin
        n_done++;
        if (sb.size() == 0) begin
          check("unexpected done", 32'(done), 0);
        end else begin
          it = sb.pop_front();
          check("done onehot", 32'(done), 32'(1) << it.idx);
          check("cs_n low clks", low_len, it.rw ? RD_CS : WR_CS);
          check("sclk rises", rise_cnt, it.rw ? 17 : 16);
          if (it.rw) begin
            check("read frame bits", s_shift[16:0], {15'd0, it.addr, 1'b1, 9'd0});
            check("rdata", 32'(rdata), 32'(it.exp_rd));
            last_rd = it.exp_rd;
          end else begin
            check("write frame bits", s_shift[15:0], {16'd0, it.addr, 1'b0, it.wdata});
            check("rdata held over write", 32'(rdata), 32'(last_rd));
          end
          have_prev = 1'b1;
        end
      end
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  end

  task automatic push(input int idx, input bit rw, input logic [6:0] addr, input logic [7:0] wd);
    item_t it;
    it.idx    = idx;
    it.rw     = rw;
    it.addr   = addr;
    it.wdata  = wd;
    it.exp_rd = ref_mem[addr];
    if (!rw) ref_mem[addr] = wd;
    sb.push_back(it);
  endtask

  task automatic set_req(input int i, input bit rw, input logic [6:0] addr, input logic [7:0] wd);
    req_rw[i]            = rw;
    req_addr[7*i +: 7]   = addr;
    req_wdata[8*i +: 8]  = wd;
    req[i]               = 1'b1;
  endtask

  task automatic wait_gnt(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!gnt[i] && n < 2000);
    check($sformatf("gnt[%0d] seen", i), 32'(gnt[i]), 1);
  endtask

  task automatic wait_done(input int i);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[i] && n < 2000);
    check($sformatf("done[%0d] seen", i), 32'(done[i]), 1);
  endtask

  task automatic frame(input int i, input bit rw, input logic [6:0] addr, input logic [7:0] wd);
    push(i, rw, addr, wd);
    set_req(i, rw, addr, wd);
    wait_gnt(i);
    req[i] = 1'b0;
    wait_done(i);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 reset = 1'b1;
    sb.delete();
    last_rd = 8'h00;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
  endtask

  initial begin
    int g0, f0, d0, n;
    for (int a = 0; a < 128; a++) begin
      s_mem[a]   = 8'(a) ^ 8'h5A;
      ref_mem[a] = 8'(a) ^ 8'h5A;
    end
    req = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset gnt", 32'(gnt), 0);
    check("reset done", 32'(done), 0);
    check("reset rdata", 32'(rdata), 0);
    check("reset busy", 32'(busy), 0);
    check("reset sclk", 32'(sclk), 1);
    check("reset cs_n", 32'(cs_n), 1);
    check("reset mosi", 32'(mosi), 0);
    #2 reset = 1'b0;

    // Basic write/read through requester 0, then requester 1 and an untouched address.
    frame(0, 1'b0, 7'h00, 8'hFF);
    frame(0, 1'b1, 7'h00, 8'h00);
    frame(1, 1'b0, 7'h55, 8'h3C);
    frame(1, 1'b1, 7'h55, 8'h00);
    frame(0, 1'b1, 7'h12, 8'h00);
    frame(1, 1'b0, 7'h2A, 8'h00);
    frame(0, 1'b1, 7'h2A, 8'h00);

    // Contention from reset: req0 keeps its request after the first grant.
    pulse_reset();
`ifdef SPI_FIXED_PRIO_EN
    push(0, 1'b0, 7'h10, 8'hA5);
    push(0, 1'b0, 7'h11, 8'hC3);
    push(1, 1'b0, 7'h20, 8'h5A);
`else
    push(0, 1'b0, 7'h10, 8'hA5);
    push(1, 1'b0, 7'h20, 8'h5A);
    push(0, 1'b0, 7'h11, 8'hC3);
`endif
    set_req(0, 1'b0, 7'h10, 8'hA5);
    set_req(1, 1'b0, 7'h20, 8'h5A);
    wait_gnt(0);
    set_req(0, 1'b0, 7'h11, 8'hC3);
`ifdef SPI_FIXED_PRIO_EN
    wait_gnt(0);
    req[0] = 1'b0;
    wait_gnt(1);
    req[1] = 1'b0;
    wait_done(1);
`else
    wait_gnt(1);
    req[1] = 1'b0;
    wait_gnt(0);
    req[0] = 1'b0;
    wait_done(0);
`endif

    // req1 raised mid-frame and withdrawn just before the arbiter would look at it.
    push(0, 1'b1, 7'h55, 8'h00);
    set_req(0, 1'b1, 7'h55, 8'h00);
    wait_gnt(0);
    req[0] = 1'b0;
    set_req(1, 1'b1, 7'h40, 8'h00);
    wait_done(0);
    repeat (GAP_CLKS - 1) @(negedge clk);
    req[1] = 1'b0;
    g0 = n_gnt;
    f0 = n_csfall;
    repeat (300) @(negedge clk);
    check("dropped req: no gnt", n_gnt - g0, 0);
    check("dropped req: no frame", n_csfall - f0, 0);
    check("dropped req: idle busy", 32'(busy), 0);

    // Asynchronous reset in the middle of a write frame.
    push(0, 1'b0, 7'h7F, 8'h81);
    set_req(0, 1'b0, 7'h7F, 8'h81);
    wait_gnt(0);
    req[0] = 1'b0;
    n = 0;
    while (s_cnt < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("reached bit 5", s_cnt, 5);
    #2 reset = 1'b1;
    #1;
    check("mid-frame reset sclk", 32'(sclk), 1);
    check("mid-frame reset cs_n", 32'(cs_n), 1);
    check("mid-frame reset busy", 32'(busy), 0);
    check("mid-frame reset rdata", 32'(rdata), 0);
    check("mid-frame reset mosi", 32'(mosi), 0);
    sb.delete();
    last_rd = 8'h00;
    d0 = n_done;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    repeat (300) @(negedge clk);
    check("no done after reset", n_done - d0, 0);
    check("slave mem untouched", 32'(s_mem[7'h7F]), 32'(8'h7F ^ 8'h5A));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
